fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port scheduler that shares the write side of one asynchronous FIFO among several requesters in the w_clk domain. It drives the FIFO write pointer handler's `w_en` and the write data, and respects the registered `full` flag. It grants one requester at a time, optionally for a bounded burst, and returns a per-requester `ack` for every word actually written.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal values are 2 or more.
- `DATA_WIDTH`, default 8: FIFO word width.
- `MAX_BURST`, default 4: maximum words per grant when bursts are enabled; legal values are 1 or more.
- `w_clk`  in  1: write-domain clock; all state updates on the rising edge.
- `w_rst`  in  1: reset, synchronous, active-high.
- `req`  in  NUM_REQ: request per requester; held high while a word is pending.
- `req_data`  in  NUM_REQ*DATA_WIDTH: word of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]; must be stable while `req[i]` is high and unacked.
- `full`  in  1: FIFO full flag from the write pointer handler (registered in w_clk).
- `w_en`  out  1: FIFO write enable.
- `w_data`  out  DATA_WIDTH: FIFO write data.
- `ack`  out  NUM_REQ: one-cycle pulse; the word of requester i is written this cycle.
- `grant`  out  NUM_REQ: one-hot registered grant; all zero when idle.
- `grant_id`  out  $clog2(NUM_REQ): index of the granted requester; holds its last value when idle.

## Operation
- States:
  - IDLE: no grant.
  - BURST: one requester holds the port.
- Arbitration is round-robin. Search starts at `last_id`+1 modulo NUM_REQ, and the first asserted `req` wins. `last_id` is updated to the winner on every new grant.
- Arbitration is evaluated on the edge where the port is free:
  - in IDLE, or
  - in BURST on the edge the current grant ends.
  - A waiting requester is therefore granted with no bubble cycle.
- Transfer is combinational from the registered grant:
  - `w_en` = |(`grant` & `req`) & !`full` & !`w_rst`.
  - `ack[i]` = `grant[i]` & `w_en`.
  - `w_data` = `req_data` slice selected by `grant_id`; it is don't-care when `w_en` is low.
- `burst_cnt` is $clog2(MAX_BURST+1) bits wide. It clears on each new grant and increments on each `w_en`.
- A grant ends at the edge where either of these holds:
  - `req[grant_id]` is low, or
  - `w_en` is high and `burst_cnt` equals MAX_BURST-1.
- When a grant ends: BURST goes to BURST with the new winner if any `req` is asserted, otherwise to IDLE.
- Full: while `full` is high, `w_en` and `ack` stay low, `burst_cnt` is frozen and the grant is held. A grant still ends if its requester drops `req`.
- If the granted requester drops `req` in the same cycle that another requester raises `req`, the new grant is given on that edge.
- A single requester that keeps `req` asserted past MAX_BURST words is re-granted immediately when no other requester is asserted. Otherwise it waits its round-robin turn.

## Timing
- Reset values: `grant`=0, `grant_id`=0, `last_id`=NUM_REQ-1 (so requester 0 wins first), `burst_cnt`=0, state IDLE. `w_en`=0 and `ack`=0 while `w_rst` is high.
- Request-to-first-write latency from IDLE: 1 cycle. `req` rises at edge k, `grant` is registered at edge k+1, and `w_en` is high in cycle k+1 if the FIFO is not full.
- Back-to-back words within a grant are written every cycle.
- Reset asserted mid-burst:
  - `w_en` drops in the same cycle.
  - State returns to IDLE at the next edge.
  - The word presented in that cycle is not acked.

## Configuration
- `FIFO_WR_ARB_BURST_EN`
  - Defined: behaviour as above, up to MAX_BURST words per grant.
  - Undefined: MAX_BURST is treated as 1. The grant ends after every written word and `burst_cnt` logic is removed, which gives strict word-interleaved round robin.

## Structure
- Package `fifo_wr_arb_pkg` holds:
  - the state enum (IDLE, BURST);
  - the function returning the $clog2 width for `grant_id` and `burst_cnt`.
- Sub-module `rr_arbiter`: combinational round-robin picker with inputs `req` and `last_id`, and outputs `valid`, `winner_id` and `winner_onehot`. The FSM, counter and datapath mux stay in `fifo_wr_arbiter`.

## Test plan
- Reset, then `req`=4'b0001 holding 3 words, `full`=0: `grant`=0001 one cycle after `req`. `ack[0]` and `w_en` are high for 3 consecutive cycles with `w_data` = the 3 words, then IDLE.
- `req`=4'b1111 held, MAX_BURST=4, burst enabled: 4 words from each requester in the order 0, 1, 2, 3, 0. There is no idle cycle between grants.
- Same stimulus with `FIFO_WR_ARB_BURST_EN` undefined: grant order is 0, 1, 2, 3, 0, … with one word each.
- Requester 2 mid-burst, `full` high for 5 cycles: `w_en`=0, `ack`=0, `grant` stays 0100 and `burst_cnt` is frozen. Writes resume the cycle after `full` falls. The total per grant stays 4.
- `w_rst` pulsed during the 2nd word of a burst: `w_en` is 0 in that cycle and `grant`=0 the next cycle. The first grant afterwards goes to the lowest asserted requester.
- Requester 1 drops `req` after 2 words while requester 3 asserts: `grant` switches to 1000 on the same edge with no bubble. Requester 3's first `ack` arrives in the next cycle.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the fifo_wr_arbiter write-port scheduler.
package fifo_wr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Index/counter width that never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-side bundle shared by the scheduler and its users.
interface fifo_wr_arbiter_if
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) ();

    localparam int IDW = cnt_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          full;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         w_data;
    logic [NUM_REQ-1:0]            ack;
    logic [NUM_REQ-1:0]            grant;
    logic [IDW-1:0]                grant_id;

    modport master (
        output req, req_data, full,
        input  w_en, w_data, ack, grant, grant_id
    );

    modport slave (
        input  req, req_data, full,
        output w_en, w_data, ack, grant, grant_id
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after last_id.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_id_i,
    output logic               valid_o,
    output logic [IDW-1:0]     winner_id_o,
    output logic [NUM_REQ-1:0] winner_onehot_o
);

    logic [IDW-1:0] idx;

    always_comb begin
        valid_o         = 1'b0;
        winner_id_o     = '0;
        winner_onehot_o = '0;
        idx             = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDW'((int'(last_id_i) + i) % NUM_REQ);
            if (!valid_o && req_i[idx]) begin
                valid_o              = 1'b1;
                winner_id_o          = idx;
                winner_onehot_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port scheduler for a shared async FIFO (w_clk domain).
// Bounded bursts per grant are enabled by defining FIFO_WR_ARB_BURST_EN.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input logic              w_clk,
    input logic              w_rst,
    fifo_wr_arbiter_if.slave bus
);

    localparam int IDW = cnt_width(NUM_REQ);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("NUM_REQ must be at least 2");
    end
    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("MAX_BURST must be at least 1");
    end

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDW-1:0]     grant_id_q;
    logic [IDW-1:0]     last_id_q;

    logic               arb_valid;
    logic [IDW-1:0]     arb_id;
    logic [NUM_REQ-1:0] arb_onehot;

    logic w_en;
    logic cur_req;
    logic last_word;
    logic grant_end;
    logic port_free;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req_i           (bus.req),
        .last_id_i       (last_id_q),
        .valid_o         (arb_valid),
        .winner_id_o     (arb_id),
        .winner_onehot_o (arb_onehot)
    );

    assign w_en      = (|(grant_q & bus.req)) & ~bus.full & ~w_rst;
    assign cur_req   = bus.req[grant_id_q];
    assign grant_end = (state_q == BURST)
                     & (~cur_req | (w_en & last_word));
    // Re-arbitrate on the closing edge so the next winner has no bubble.
    assign port_free = (state_q == IDLE) | grant_end;

    assign bus.w_en     = w_en;
    assign bus.ack      = grant_q & {NUM_REQ{w_en}};
    assign bus.w_data   = bus.req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    assign bus.grant    = grant_q;
    assign bus.grant_id = grant_id_q;

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int CW = cnt_width(MAX_BURST + 1);

    logic [CW-1:0] burst_cnt_q;
    logic [CW-1:0] burst_cnt_d;

    assign last_word = (burst_cnt_q == CW'(MAX_BURST - 1));

    // Frozen while full because w_en is low then.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (port_free) begin
            burst_cnt_d = '0;
        end else if (w_en) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign last_word = 1'b1;
`endif

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_id_q  <= IDW'(NUM_REQ - 1);
        end else if (port_free) begin
            if (arb_valid) begin
                state_q    <= BURST;
                grant_q    <= arb_onehot;
                grant_id_q <= arb_id;
                last_id_q  <= arb_id;
            end else begin
                state_q <= IDLE;
                grant_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter; expected writes are queued by stimulus.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;
`ifdef FIFO_WR_ARB_BURST_EN
    localparam int EFF = MB;
`else
    localparam int EFF = 1;
`endif

    typedef struct {
        int            id;
        logic [DW-1:0] d;
    } exp_t;

    logic w_clk = 1'b0;
    logic w_rst = 1'b1;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .bus   (bus)
    );

    always #5 w_clk = ~w_clk;

    logic [DW-1:0] wq [NR][$];
    exp_t          exp_q [$];
    logic [NR-1:0] ack_prev = '0;
    int            n_cmp = 0;
    int            n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] wd(input int r, input int j);
        return DW'((r << 4) | j);
    endfunction

    // Monitor: every written word must match the head of the scoreboard.
    always @(negedge w_clk) begin
        exp_t e;
        ack_prev = bus.ack;
        if (bus.w_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got data %0h, expected no write", bus.w_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_id", int'(bus.grant_id), e.id);
                chk("wr_ack", int'(bus.ack), 1 << e.id);
                chk("wr_data", int'(bus.w_data), int'(e.d));
            end
        end else begin
            chk("ack_idle", int'(bus.ack), 0);
        end
    end

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req[i] = (wq[i].size() != 0);
            bus.req_data[i*DW +: DW] = (wq[i].size() != 0) ? wq[i][0] : '0;
        end
    endtask

    // Requesters retire their head word after each ack, then re-drive.
    task automatic tick();
        @(posedge w_clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (ack_prev[i] && wq[i].size() != 0) void'(wq[i].pop_front());
        end
        drive();
    endtask

    task automatic give(input int r, input int n);
        for (int j = 0; j < n; j++) wq[r].push_back(wd(r, j));
    endtask

    task automatic ex(input int r, input int j);
        exp_q.push_back('{r, wd(r, j)});
    endtask

    function automatic bit busy();
        for (int i = 0; i < NR; i++) if (wq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy()) && n < budget) begin
            tick();
            n++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        w_rst = 1'b1;
        tick();
        tick();
        w_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus.full = 1'b0;
        drive();

        // Reset values
        tick();
        #1;
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_wen", int'(bus.w_en), 0);
        tick();
        #1;
        chk("rst_grant_id", int'(bus.grant_id), 0);
        w_rst = 1'b0;

        // A: single requester, three words
        give(0, 3);
        for (int j = 0; j < 3; j++) ex(0, j);
        drive();
        #1;
        chk("a_pre_grant", int'(bus.grant), 0);
        for (int j = 0; j < 3; j++) begin
            tick();
            #1;
            chk("a_grant", int'(bus.grant), 1);
            chk("a_wen", int'(bus.w_en), 1);
            chk("a_data", int'(bus.w_data), int'(wd(0, j)));
        end
        tick();
        #1;
        chk("a_tail_wen", int'(bus.w_en), 0);
        tick();
        #1;
        chk("a_idle_grant", int'(bus.grant), 0);
        chk("a_idle_id", int'(bus.grant_id), 0);
        chk("a_sb_empty", exp_q.size(), 0);

        // B: all four requesting, round-robin bursts with no bubble
        do_reset();
        for (int r = 0; r < NR; r++) give(r, 8);
        for (int rnd = 0; rnd < 8 / EFF; rnd++)
            for (int r = 0; r < NR; r++)
                for (int k = 0; k < EFF; k++) ex(r, rnd * EFF + k);
        drive();
        tick();
        cnt = 0;
        for (int c = 0; c < 32; c++) begin
            #1;
            if (bus.w_en) cnt++;
            tick();
        end
        chk("b_no_bubble", cnt, 32);
        wait_idle("b_sb_empty", 20);

        // D: full stalls requester 2 mid-burst
        do_reset();
        give(2, 6);
        give(3, 2);
`ifdef FIFO_WR_ARB_BURST_EN
        for (int j = 0; j < 4; j++) ex(2, j);
        ex(3, 0); ex(3, 1); ex(2, 4); ex(2, 5);
`else
        ex(2, 0); ex(3, 0); ex(2, 1); ex(3, 1);
        for (int j = 2; j < 6; j++) ex(2, j);
`endif
        drive();
        tick();
        #1;
        chk("d_grant", int'(bus.grant), 4);
        tick();
        tick();
        bus.full = 1'b1;
        #1;
        chk("d_full_wen", int'(bus.w_en), 0);
        chk("d_full_ack", int'(bus.ack), 0);
        chk("d_full_grant", int'(bus.grant), 4);
        for (int k = 1; k < 5; k++) begin
            tick();
            #1;
            chk("d_full_wen", int'(bus.w_en), 0);
            chk("d_full_grant", int'(bus.grant), 4);
        end
        tick();
        bus.full = 1'b0;
        #1;
        chk("d_resume_wen", int'(bus.w_en), 1);
        chk("d_resume_grant", int'(bus.grant), 4);
        wait_idle("d_sb_empty", 30);

        // E: reset pulse on the second word of a burst
        do_reset();
        give(1, 4);
        give(3, 2);
`ifdef FIFO_WR_ARB_BURST_EN
        for (int j = 0; j < 4; j++) ex(1, j);
        ex(3, 0); ex(3, 1);
`else
        ex(1, 0); ex(1, 1); ex(3, 0); ex(1, 2); ex(3, 1); ex(1, 3);
`endif
        drive();
        tick();
        #1;
        chk("e_grant", int'(bus.grant), 2);
        chk("e_wen", int'(bus.w_en), 1);
        tick();
        w_rst = 1'b1;
        #1;
        chk("e_rst_wen", int'(bus.w_en), 0);
        chk("e_rst_ack", int'(bus.ack), 0);
        tick();
        #1;
        chk("e_rst_grant", int'(bus.grant), 0);
        w_rst = 1'b0;
        tick();
        #1;
        chk("e_regrant", int'(bus.grant), 2);
        chk("e_regrant_data", int'(bus.w_data), int'(wd(1, 1)));
        wait_idle("e_sb_empty", 30);

        // F: requester 1 drops as requester 3 raises
        do_reset();
        give(1, 2);
        ex(1, 0); ex(1, 1); ex(3, 0); ex(3, 1);
        drive();
        tick();
        tick();
        tick();
        give(3, 2);
        drive();
        #1;
        chk("f_hold_grant", int'(bus.grant), 2);
        chk("f_gap_wen", int'(bus.w_en), 0);
        tick();
        #1;
        chk("f_switch_grant", int'(bus.grant), 8);
        chk("f_ack3", int'(bus.ack), 8);
        wait_idle("f_sb_empty", 20);
        tick();
        tick();
        #1;
        chk("f_idle_grant", int'(bus.grant), 0);
        chk("f_idle_id", int'(bus.grant_id), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
